collision_checker: RTL and testbench

//  Downstream consumer of the bullet generator/mover. Once per game tick it snapshots enemy,

---
 rtl/game_pkg.sv | 37 +++
 rtl/aabb_overlap.sv | 29 ++
 rtl/collision_checker.sv | 200 ++++++++++++++++++++
 tb/tb_collision_checker.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared game constants, position helpers and collision FSM encoding
//   Slot counts, display and sprite sizes, packed position layout {x[9:0], y[8:0]},
//   the off-screen DEAD_POSITION marker and the collision_checker state type.
package game_pkg;
    localparam int MAX_ENEMY         = 15;
    localparam int MAX_ENEMY_BULLET  = 30;
    localparam int MAX_PLAYER_BULLET = 16;
    localparam int DISPLAY_WIDTH     = 640;
    localparam int DISPLAY_HEIGHT    = 480;
    localparam int BULLET_WIDTH      = 6;
    localparam int BULLET_HEIGHT     = 20;
    localparam int ENEMY_WIDTH       = 32;
    localparam int ENEMY_HEIGHT      = 32;
    localparam int PLAYER_WIDTH      = 32;
    localparam int PLAYER_HEIGHT     = 32;
    localparam int POS_W             = 19;
    localparam int X_W               = 10;
    localparam int Y_W               = 9;
    // One extra bit over X_W so coordinate + box size never wraps.
    localparam int BOX_W             = 11;
    localparam logic [POS_W-1:0] DEAD_POSITION = 19'h7FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN_P,
        ST_SCAN_E,
        ST_DONE
    } state_t;

    function automatic logic [X_W-1:0] pos_x(input logic [POS_W-1:0] p);
        return p[POS_W-1:Y_W];
    endfunction

    function automatic logic [Y_W-1:0] pos_y(input logic [POS_W-1:0] p);
        return p[Y_W-1:0];
    endfunction
endpackage

// File: rtl/aabb_overlap.sv
// aabb_overlap: combinational strict axis-aligned bounding-box overlap test
//   i_AX/i_AY, i_AW/i_AH : box A corner and size
//   i_BX/i_BY, i_BW/i_BH : box B corner and size
//   o_Overlap            : 1 when the boxes overlap; touching edges do not count
module aabb_overlap #(
    parameter int W  = 11,
    parameter int XW = 10,
    parameter int YW = 9
) (
    input  logic [XW-1:0] i_AX,
    input  logic [YW-1:0] i_AY,
    input  logic [W-1:0]  i_AW,
    input  logic [W-1:0]  i_AH,
    input  logic [XW-1:0] i_BX,
    input  logic [YW-1:0] i_BY,
    input  logic [W-1:0]  i_BW,
    input  logic [W-1:0]  i_BH,
    output logic          o_Overlap
);
    logic [W-1:0] w_ax, w_ay, w_bx, w_by;

    assign w_ax = W'(i_AX);
    assign w_ay = W'(i_AY);
    assign w_bx = W'(i_BX);
    assign w_by = W'(i_BY);

    assign o_Overlap = (w_ax < w_bx + i_BW) && (w_bx < w_ax + i_AW) &&
                       (w_ay < w_by + i_BH) && (w_by < w_ay + i_AH);
endmodule

// File: rtl/collision_checker.sv
// collision_checker: per-tick serial bullet/target collision scan producing hit masks
//   i_Clk, i_Rst (sync, active-high), i_fTick starts a scan of the snapshotted inputs
//   i_Enemy*/i_PlayerBullet*/i_EnemyBullet*/i_Player* : alive/valid masks and packed positions
//   o_EnemyHit, o_PlayerBulletHit, o_EnemyBulletHit, o_PlayerHit : results, held until next done
//   o_fBusy : scan in progress; o_fDone : results valid pulse; o_fOverrun : tick while busy
//   Optional macro COLLISION_SCORE_EN adds o_Score, a saturating kill counter.
module collision_checker
    import game_pkg::*;
#(
    parameter int MAX_EN = MAX_ENEMY,
    parameter int MAX_PB = MAX_PLAYER_BULLET,
    parameter int MAX_EB = MAX_ENEMY_BULLET,
    parameter int BW     = BULLET_WIDTH,
    parameter int BH     = BULLET_HEIGHT,
    parameter int EW     = ENEMY_WIDTH,
    parameter int EH     = ENEMY_HEIGHT,
    parameter int PW     = PLAYER_WIDTH,
    parameter int PH     = PLAYER_HEIGHT
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic                    i_fTick,
    input  logic [MAX_EN-1:0]       i_EnemyState,
    input  logic [POS_W*MAX_EN-1:0] i_EnemyPosition,
    input  logic [MAX_PB-1:0]       i_PlayerBulletState,
    input  logic [POS_W*MAX_PB-1:0] i_PlayerBulletPosition,
    input  logic [MAX_EB-1:0]       i_EnemyBulletState,
    input  logic [POS_W*MAX_EB-1:0] i_EnemyBulletPosition,
    input  logic                    i_PlayerState,
    input  logic [POS_W-1:0]        i_PlayerPosition,
    output logic [MAX_EN-1:0]       o_EnemyHit,
    output logic [MAX_PB-1:0]       o_PlayerBulletHit,
    output logic [MAX_EB-1:0]       o_EnemyBulletHit,
    output logic                    o_PlayerHit,
    output logic                    o_fBusy,
    output logic                    o_fDone,
`ifdef COLLISION_SCORE_EN
    output logic [15:0]             o_Score,
`endif
    output logic                    o_fOverrun
);
    localparam int PB_CW = $clog2(MAX_PB);
    localparam int EN_CW = $clog2(MAX_EN);
    localparam int EB_CW = $clog2(MAX_EB);

    state_t r_state, w_next_state;

    logic [MAX_EN-1:0]       r_en_st, r_en_acc, r_en_hit;
    logic [POS_W*MAX_EN-1:0] r_en_pos;
    logic [MAX_PB-1:0]       r_pb_st, r_pb_acc, r_pb_hit;
    logic [POS_W*MAX_PB-1:0] r_pb_pos;
    logic [MAX_EB-1:0]       r_eb_st, r_eb_acc, r_eb_hit;
    logic [POS_W*MAX_EB-1:0] r_eb_pos;
    logic                    r_pl_st, r_pl_hit, r_overrun;
    logic [POS_W-1:0]        r_pl_pos;
    logic [PB_CW-1:0]        r_pb;
    logic [EN_CW-1:0]        r_en;
    logic [EB_CW-1:0]        r_eb;

    logic                    w_scan_e, w_last_en, w_last_p, w_last_e;
    logic                    w_pair_ok, w_overlap, w_hit;
    logic [POS_W-1:0]        w_bpos, w_tpos;
    logic [BOX_W-1:0]        w_tw, w_th;
    logic [MAX_EB-1:0]       w_eb_final;

    assign w_scan_e  = r_state == ST_SCAN_E;
    assign w_last_en = r_en == EN_CW'(MAX_EN - 1);
    assign w_last_p  = w_last_en && r_pb == PB_CW'(MAX_PB - 1);
    assign w_last_e  = r_eb == EB_CW'(MAX_EB - 1);

    // Single comparator shared by both phases: bullet is box A, target is box B.
    assign w_bpos = w_scan_e ? r_eb_pos[POS_W*int'(r_eb) +: POS_W]
                             : r_pb_pos[POS_W*int'(r_pb) +: POS_W];
    assign w_tpos = w_scan_e ? r_pl_pos : r_en_pos[POS_W*int'(r_en) +: POS_W];
    assign w_tw   = w_scan_e ? BOX_W'(PW) : BOX_W'(EW);
    assign w_th   = w_scan_e ? BOX_W'(PH) : BOX_W'(EH);

    // Bullets and enemies already hit this scan drop out, so each bullet kills
    // at most one enemy and the lowest enemy index wins.
    assign w_pair_ok = w_scan_e ? (r_pl_st && r_eb_st[r_eb])
                                : (r_pb_st[r_pb] && !r_pb_acc[r_pb] &&
                                   r_en_st[r_en] && !r_en_acc[r_en]);
    assign w_hit      = w_pair_ok && w_overlap;
    // Enemy-bullet mask including the pair being evaluated this cycle.
    assign w_eb_final = r_eb_acc | (MAX_EB'(w_hit) << r_eb);

    aabb_overlap #(
        .W  (BOX_W),
        .XW (X_W),
        .YW (Y_W)
    ) u_aabb (
        .i_AX      (pos_x(w_bpos)),
        .i_AY      (pos_y(w_bpos)),
        .i_AW      (BOX_W'(BW)),
        .i_AH      (BOX_W'(BH)),
        .i_BX      (pos_x(w_tpos)),
        .i_BY      (pos_y(w_tpos)),
        .i_BW      (w_tw),
        .i_BH      (w_th),
        .o_Overlap (w_overlap)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Rst) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = (r_state == ST_IDLE)   ? (i_fTick  ? ST_SCAN_P : ST_IDLE)   :
                       (r_state == ST_SCAN_P) ? (w_last_p ? ST_SCAN_E : ST_SCAN_P) :
                       (r_state == ST_SCAN_E) ? (w_last_e ? ST_DONE   : ST_SCAN_E) :
                                                ST_IDLE;
    end

    always_comb begin
        o_fBusy = r_state != ST_IDLE;
        o_fDone = r_state == ST_DONE;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_en_st   <= '0;
            r_en_pos  <= '0;
            r_pb_st   <= '0;
            r_pb_pos  <= '0;
            r_eb_st   <= '0;
            r_eb_pos  <= '0;
            r_pl_st   <= 1'b0;
            r_pl_pos  <= '0;
            r_en_acc  <= '0;
            r_pb_acc  <= '0;
            r_eb_acc  <= '0;
            r_pb      <= '0;
            r_en      <= '0;
            r_eb      <= '0;
            r_en_hit  <= '0;
            r_pb_hit  <= '0;
            r_eb_hit  <= '0;
            r_pl_hit  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= i_fTick && r_state != ST_IDLE;
            if (r_state == ST_IDLE && i_fTick) begin
                r_en_st  <= i_EnemyState;
                r_en_pos <= i_EnemyPosition;
                r_pb_st  <= i_PlayerBulletState;
                r_pb_pos <= i_PlayerBulletPosition;
                r_eb_st  <= i_EnemyBulletState;
                r_eb_pos <= i_EnemyBulletPosition;
                r_pl_st  <= i_PlayerState;
                r_pl_pos <= i_PlayerPosition;
                r_en_acc <= '0;
                r_pb_acc <= '0;
                r_eb_acc <= '0;
                r_pb     <= '0;
                r_en     <= '0;
                r_eb     <= '0;
            end
            if (r_state == ST_SCAN_P) begin
                if (w_hit) begin
                    r_pb_acc[r_pb] <= 1'b1;
                    r_en_acc[r_en] <= 1'b1;
                end
                r_en <= w_last_en ? '0 : r_en + 1'b1;
                if (w_last_en) r_pb <= r_pb + 1'b1;
            end
            if (w_scan_e) begin
                r_eb_acc <= w_eb_final;
                r_eb     <= r_eb + 1'b1;
                // Publish on the edge into DONE so results are valid with o_fDone.
                if (w_last_e) begin
                    r_en_hit <= r_en_acc;
                    r_pb_hit <= r_pb_acc;
                    r_eb_hit <= w_eb_final;
                    r_pl_hit <= |w_eb_final;
                end
            end
        end
    end

    assign o_EnemyHit        = r_en_hit;
    assign o_PlayerBulletHit = r_pb_hit;
    assign o_EnemyBulletHit  = r_eb_hit;
    assign o_PlayerHit       = r_pl_hit;
    assign o_fOverrun        = r_overrun;

`ifdef COLLISION_SCORE_EN
    logic [15:0] r_score;
    logic [16:0] w_score_sum;

    assign w_score_sum = {1'b0, r_score} + 17'($countones(r_en_acc));

    always_ff @(posedge i_Clk) begin
        if (i_Rst)                  r_score <= '0;
        else if (w_scan_e && w_last_e) r_score <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
    end

    assign o_Score = r_score;
`endif
endmodule

// File: tb/tb_collision_checker.sv
// tb_collision_checker: directed and randomized scans checked against a loop-based reference model
module tb_collision_checker;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic [14:0]   en_st = '0;
    logic [284:0]  en_pos = '0;
    logic [15:0]   pb_st = '0;
    logic [303:0]  pb_pos = '0;
    logic [29:0]   eb_st = '0;
    logic [569:0]  eb_pos = '0;
    logic          pl_st = 1'b0;
    logic [18:0]   pl_pos = '0;
    logic [14:0]   o_en;
    logic [15:0]   o_pb;
    logic [29:0]   o_eb;
    logic          o_ph, o_busy, o_done, o_ovr;

    int total = 0;
    int bad = 0;
    logic [14:0] exp_en, prev_en;
    logic [15:0] exp_pb, prev_pb;
    logic [29:0] exp_eb, prev_eb;
    logic        exp_ph, prev_ph;

    always #5 clk = ~clk;

    collision_checker dut (
        .i_Clk                  (clk),
        .i_Rst                  (rst),
        .i_fTick                (tick),
        .i_EnemyState           (en_st),
        .i_EnemyPosition        (en_pos),
        .i_PlayerBulletState    (pb_st),
        .i_PlayerBulletPosition (pb_pos),
        .i_EnemyBulletState     (eb_st),
        .i_EnemyBulletPosition  (eb_pos),
        .i_PlayerState          (pl_st),
        .i_PlayerPosition       (pl_pos),
        .o_EnemyHit             (o_en),
        .o_PlayerBulletHit      (o_pb),
        .o_EnemyBulletHit       (o_eb),
        .o_PlayerHit            (o_ph),
        .o_fBusy                (o_busy),
        .o_fDone                (o_done),
        .o_fOverrun             (o_ovr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] mkpos(input int x, input int y);
        logic [9:0] xx;
        logic [8:0] yy;
        xx = 10'(x);
        yy = 9'(y);
        return {xx, yy};
    endfunction

    function automatic int gx(input logic [18:0] p);
        return int'(p[18:9]);
    endfunction

    function automatic int gy(input logic [18:0] p);
        return int'(p[8:0]);
    endfunction

    function automatic bit ovl(input int bx, input int by, input int bw, input int bh,
                               input int ex, input int ey, input int ew, input int eh);
        return bx < ex + ew && ex < bx + bw && by < ey + eh && ey < by + bh;
    endfunction

    // Reference: every pair in bullet-major order, first free enemy wins.
    task automatic model();
        logic [18:0] b, t;
        exp_en = '0;
        exp_pb = '0;
        exp_eb = '0;
        for (int p = 0; p < 16; p++) begin
            if (!pb_st[p]) continue;
            b = pb_pos[p*19 +: 19];
            for (int e = 0; e < 15; e++) begin
                t = en_pos[e*19 +: 19];
                if (!exp_pb[p] && en_st[e] && !exp_en[e] &&
                    ovl(gx(b), gy(b), 6, 20, gx(t), gy(t), 32, 32)) begin
                    exp_pb[p] = 1'b1;
                    exp_en[e] = 1'b1;
                end
            end
        end
        for (int e = 0; e < 30; e++) begin
            b = eb_pos[e*19 +: 19];
            if (pl_st && eb_st[e] && ovl(gx(b), gy(b), 6, 20, gx(pl_pos), gy(pl_pos), 32, 32))
                exp_eb[e] = 1'b1;
        end
        exp_ph = |exp_eb;
    endtask

    task automatic clear_inputs();
        en_st = '0; en_pos = '0; pb_st = '0; pb_pos = '0;
        eb_st = '0; eb_pos = '0; pl_st = 1'b0; pl_pos = '0;
    endtask

    task automatic randomize_inputs();
        en_st = 15'($urandom);
        pb_st = 16'($urandom);
        eb_st = 30'($urandom);
        pl_st = 1'($urandom);
        pl_pos = mkpos($urandom_range(100, 160), $urandom_range(100, 160));
        for (int i = 0; i < 15; i++) en_pos[i*19 +: 19] = mkpos($urandom_range(100, 180), $urandom_range(100, 180));
        for (int i = 0; i < 16; i++) pb_pos[i*19 +: 19] = mkpos($urandom_range(100, 180), $urandom_range(100, 180));
        for (int i = 0; i < 30; i++) eb_pos[i*19 +: 19] = mkpos($urandom_range(90, 200), $urandom_range(90, 200));
    endtask

    // One scan: optional overrun tick / reset at cycle offsets (-1 = none),
    // optional input scrambling right after the snapshot.
    task automatic run_scan(input string tag, input int ovr_at, input int rst_at, input bit scramble);
        int  n;
        bit  done_seen;
        model();
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        chk({tag, "_busy"}, 32'(o_busy), 32'd1);
        chk({tag, "_hold"}, 32'(o_en), 32'(prev_en));
        if (scramble) randomize_inputs();
        n = 0;
        done_seen = 0;
        while (n < 400 && !done_seen) begin
            if (n == ovr_at) tick = 1'b1;
            if (n == rst_at) rst = 1'b1;
            @(posedge clk);
            #1;
            n++;
            tick = 1'b0;
            if (ovr_at >= 0 && n == ovr_at + 1) chk({tag, "_ovr"}, 32'(o_ovr), 32'd1);
            if (rst_at >= 0 && n == rst_at + 1) begin
                rst = 1'b0;
                chk({tag, "_rst_en"}, 32'(o_en), 32'd0);
                chk({tag, "_rst_flags"}, {29'd0, o_ph, o_busy, o_done}, 32'd0);
                for (int k = 0; k < 300; k++) begin
                    @(posedge clk);
                    #1;
                    if (o_done) done_seen = 1;
                end
                chk({tag, "_rst_nodone"}, 32'(done_seen), 32'd0);
                prev_en = '0; prev_pb = '0; prev_eb = '0; prev_ph = 1'b0;
                return;
            end
            if (o_done) done_seen = 1;
        end
        chk({tag, "_latency"}, 32'(n), 32'd270);
        chk({tag, "_en"}, 32'(o_en), 32'(exp_en));
        chk({tag, "_pb"}, 32'(o_pb), 32'(exp_pb));
        chk({tag, "_eb"}, 32'(o_eb), 32'(exp_eb));
        chk({tag, "_ph"}, 32'(o_ph), 32'(exp_ph));
        @(posedge clk);
        #1;
        chk({tag, "_idle"}, {30'd0, o_busy, o_done}, 32'd0);
        prev_en = exp_en; prev_pb = exp_pb; prev_eb = exp_eb; prev_ph = exp_ph;
    endtask

    initial begin
        prev_en = '0; prev_pb = '0; prev_eb = '0; prev_ph = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_masks", {1'b0, o_en, o_pb}, 32'd0);
        chk("reset_eb", 32'(o_eb), 32'd0);
        chk("reset_flags", {28'd0, o_ph, o_busy, o_done, o_ovr}, 32'd0);
        rst = 1'b0;

        run_scan("empty", -1, -1, 0);

        pb_st[0] = 1'b1; pb_pos[0 +: 19] = mkpos(100, 200);
        en_st[3] = 1'b1; en_pos[3*19 +: 19] = mkpos(98, 190);
        run_scan("single", -1, -1, 0);
        chk("single_const_en", 32'(o_en), 32'h0008);
        chk("single_const_pb", 32'(o_pb), 32'h0001);

        pb_st[1] = 1'b1; pb_pos[19 +: 19] = mkpos(102, 195);
        run_scan("two_pb", -1, -1, 0);
        chk("two_pb_const", 32'(o_pb), 32'h0001);

        clear_inputs();
        pb_st[0] = 1'b1; pb_pos[0 +: 19] = mkpos(132, 200);
        en_st[3] = 1'b1; en_pos[3*19 +: 19] = mkpos(100, 190);
        run_scan("touch", -1, -1, 0);
        chk("touch_const", {1'b0, o_en, o_pb}, 32'd0);

        clear_inputs();
        pl_st = 1'b1; pl_pos = mkpos(300, 440);
        eb_st[5] = 1'b1; eb_pos[5*19 +: 19] = mkpos(310, 450);
        eb_st[7] = 1'b1; eb_pos[7*19 +: 19] = mkpos(305, 430);
        eb_st[2] = 1'b1; eb_pos[2*19 +: 19] = mkpos(100, 100);
        run_scan("pl_alive", -1, -1, 0);
        chk("pl_alive_const", {1'b0, o_ph, o_eb}, {2'b01, 30'h000000A0});

        pl_st = 1'b0;
        run_scan("pl_dead", -1, -1, 0);

        randomize_inputs();
        run_scan("overrun", 100, -1, 1);

        randomize_inputs();
        run_scan("midrst", -1, 150, 0);

        for (int r = 0; r < 6; r++) begin
            randomize_inputs();
            run_scan($sformatf("rand%0d", r), -1, -1, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
